// File: rtl/fc_seq_ctrl.sv
// rtl/fc_seq_ctrl.sv - FC1/FC2 sequencer: weight/activation addressing, MAC strobes, e/f write commands
module fc_seq_ctrl #(
    parameter int WEIGHT_ADDR_WIDTH = 15,
    parameter int FC1_NEURONS       = 500,
    parameter int FC1_WORDS         = 40,
    parameter int FC2_NEURONS       = 10,
    parameter int FC2_WORDS         = 25,
    parameter int FC2_WEIGHT_BASE   = 20000,
    parameter int MAC_LAT           = 2
) (
    input  logic                         clk,
    input  logic                         srstn,
    input  logic                         conv_done,
    input  logic                         mem_sel,
    output logic [WEIGHT_ADDR_WIDTH-1:0] sram_raddr_weight,
    output logic [9:0]                   act_raddr,
    output logic [1:0]                   act_src,
    output logic                         mac_valid,
    output logic                         mac_first,
    output logic                         mac_last,
    output logic                         layer,
    output logic [4:0]                   sram_write_enable_e,
    output logic [9:0]                   sram_waddr_e,
    output logic [3:0]                   sram_bytemask_e,
    output logic                         sram_write_enable_f,
    output logic [9:0]                   sram_waddr_f,
    output logic [3:0]                   sram_bytemask_f,
    output logic                         fc1_done,
    output logic                         fc2_done,
    output logic                         busy
);
    localparam int NMAX = (FC1_NEURONS > FC2_NEURONS) ? FC1_NEURONS : FC2_NEURONS;
    localparam int WMAX = (FC1_WORDS > FC2_WORDS) ? FC1_WORDS : FC2_WORDS;
    localparam int NW   = (NMAX > 2) ? $clog2(NMAX) : 1;
    localparam int JW   = (WMAX > 2) ? $clog2(WMAX) : 1;
    localparam logic [NW-1:0] FC1_NL = NW'(FC1_NEURONS - 1);
    localparam logic [NW-1:0] FC2_NL = NW'(FC2_NEURONS - 1);
    localparam logic [JW-1:0] FC1_WL = JW'(FC1_WORDS - 1);
    localparam logic [JW-1:0] FC2_WL = JW'(FC2_WORDS - 1);
    localparam logic [WEIGHT_ADDR_WIDTH-1:0] FC2_BASE = WEIGHT_ADDR_WIDTH'(FC2_WEIGHT_BASE);

    typedef enum logic [2:0] {S_IDLE, S_FC1, S_FC1_DRAIN, S_FC2, S_FC2_DRAIN} state_t;

    state_t                       state_q;
    logic [WEIGHT_ADDR_WIDTH-1:0] raddr_q;
    logic [JW-1:0]                j_q, j_d;
    logic [NW-1:0]                n_q, n_d, wn_q;
    logic [1:0]                   src_q;
    logic                         issue_v_q, issue_first_q, issue_last_q;
    logic                         mac_valid_q, mac_first_q, mac_last_q, layer_q;
    logic [MAC_LAT-1:0]           wr_pipe_q;
    logic                         wr_last_q;
    logic [1:0]                   wbyte_q;
    logic [2:0]                   wbank_q;
    logic [9:0]                   wrow_q;
    logic [4:0]                   we_e_q;
    logic [9:0]                   waddr_e_q, waddr_f_q;
    logic [3:0]                   mask_e_q, mask_f_q;
    logic                         we_f_q, fc1_done_q, fc2_done_q, busy_q;
    logic                         in_fc2, last_word, last_neuron, wr_l2, wn_last, wr_go;
    logic                         first_d, last_d;

    always_comb begin
        in_fc2      = (state_q == S_FC2);
        last_word   = in_fc2 ? (j_q == FC2_WL) : (j_q == FC1_WL);
        last_neuron = in_fc2 ? (n_q == FC2_NL) : (n_q == FC1_NL);
        j_d         = last_word ? '0 : j_q + JW'(1);
        n_d         = last_word ? n_q + NW'(1) : n_q;
        first_d     = (j_d == '0);
        last_d      = in_fc2 ? (j_d == FC2_WL) : (j_d == FC1_WL);
        wr_l2       = (state_q == S_FC2) || (state_q == S_FC2_DRAIN);
        wn_last     = wr_l2 ? (wn_q == FC2_NL) : (wn_q == FC1_NL);
        wr_go       = wr_pipe_q[MAC_LAT-1];
    end

    always_ff @(posedge clk) begin
        if (!srstn) begin
            state_q       <= S_IDLE;
            raddr_q       <= '0;
            j_q           <= '0;
            n_q           <= '0;
            wn_q          <= '0;
            src_q         <= 2'd0;
            issue_v_q     <= 1'b0;
            issue_first_q <= 1'b0;
            issue_last_q  <= 1'b0;
            mac_valid_q   <= 1'b0;
            mac_first_q   <= 1'b0;
            mac_last_q    <= 1'b0;
            layer_q       <= 1'b0;
            wr_pipe_q     <= '0;
            wr_last_q     <= 1'b0;
            wbyte_q       <= 2'd0;
            wbank_q       <= 3'd0;
            wrow_q        <= 10'd0;
            we_e_q        <= 5'h1F;
            waddr_e_q     <= 10'd0;
            mask_e_q      <= 4'hF;
            we_f_q        <= 1'b1;
            waddr_f_q     <= 10'd0;
            mask_f_q      <= 4'hF;
            fc1_done_q    <= 1'b0;
            fc2_done_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            fc1_done_q  <= 1'b0;
            fc2_done_q  <= 1'b0;
            mac_valid_q <= issue_v_q;
            mac_first_q <= issue_v_q & issue_first_q;
            mac_last_q  <= issue_v_q & issue_last_q;
            // Neuron-complete tokens age MAC_LAT cycles past mac_last before the write strobe
            wr_pipe_q[0] <= issue_v_q & issue_last_q;
            for (int k = 1; k < MAC_LAT; k++) wr_pipe_q[k] <= wr_pipe_q[k-1];

            we_e_q    <= 5'h1F;
            we_f_q    <= 1'b1;
            mask_e_q  <= 4'hF;
            mask_f_q  <= 4'hF;
            wr_last_q <= 1'b0;
            if (wr_go) begin
                if (wr_l2) begin
                    we_f_q    <= 1'b0;
                    waddr_f_q <= wrow_q;
                    mask_f_q  <= ~(4'b1000 >> wbyte_q);
                end else begin
                    we_e_q    <= ~(5'b00001 << wbank_q);
                    waddr_e_q <= wrow_q;
                    mask_e_q  <= ~(4'b1000 >> wbyte_q);
                end
                if (wn_last) begin
                    wn_q      <= '0;
                    wbyte_q   <= 2'd0;
                    wbank_q   <= 3'd0;
                    wrow_q    <= 10'd0;
                    wr_last_q <= 1'b1;
                end else begin
                    wn_q    <= wn_q + NW'(1);
                    wbyte_q <= wbyte_q + 2'd1;
                    if (wbyte_q == 2'd3) begin
                        if (wr_l2 || wbank_q == 3'd4) begin
                            wbank_q <= 3'd0;
                            wrow_q  <= wrow_q + 10'd1;
                        end else begin
                            wbank_q <= wbank_q + 3'd1;
                        end
                    end
                end
            end

            case (state_q)
                S_IDLE: begin
                    busy_q <= conv_done;
                    if (conv_done) begin
                        state_q       <= S_FC1;
                        raddr_q       <= '0;
                        j_q           <= '0;
                        n_q           <= '0;
                        src_q         <= mem_sel ? 2'd0 : 2'd1;
                        layer_q       <= 1'b0;
                        issue_v_q     <= 1'b1;
                        issue_first_q <= 1'b1;
                        issue_last_q  <= (FC1_WL == '0);
                    end
                end
                S_FC1, S_FC2: begin
                    if (last_word && last_neuron) begin
                        state_q   <= in_fc2 ? S_FC2_DRAIN : S_FC1_DRAIN;
                        issue_v_q <= 1'b0;
                    end else begin
                        raddr_q       <= raddr_q + WEIGHT_ADDR_WIDTH'(1);
                        j_q           <= j_d;
                        n_q           <= n_d;
                        issue_v_q     <= 1'b1;
                        issue_first_q <= first_d;
                        issue_last_q  <= last_d;
                    end
                end
                S_FC1_DRAIN: begin
                    if (wr_last_q) begin
                        fc1_done_q    <= 1'b1;
                        state_q       <= S_FC2;
                        raddr_q       <= FC2_BASE;
                        j_q           <= '0;
                        n_q           <= '0;
                        src_q         <= 2'd2;
                        layer_q       <= 1'b1;
                        issue_v_q     <= 1'b1;
                        issue_first_q <= 1'b1;
                        issue_last_q  <= (FC2_WL == '0);
                    end
                end
                S_FC2_DRAIN: begin
                    if (wr_last_q) begin
                        fc2_done_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign sram_raddr_weight   = raddr_q;
    assign act_raddr           = 10'(j_q);
    assign act_src             = src_q;
    assign mac_valid           = mac_valid_q;
    assign mac_first           = mac_first_q;
    assign mac_last            = mac_last_q;
    assign layer               = layer_q;
    assign sram_write_enable_e = we_e_q;
    assign sram_waddr_e        = waddr_e_q;
    assign sram_bytemask_e     = mask_e_q;
    assign sram_write_enable_f = we_f_q;
    assign sram_waddr_f        = waddr_f_q;
    assign sram_bytemask_f     = mask_f_q;
    assign fc1_done            = fc1_done_q;
    assign fc2_done            = fc2_done_q;
    assign busy                = busy_q;
endmodule

// File: tb/tb_fc_seq_ctrl.sv
// tb/tb_fc_seq_ctrl.sv - cycle-indexed arithmetic model plus literal pins for fc_seq_ctrl
module tb_fc_seq_ctrl;
    localparam int ML    = 2;
    localparam int N1    = 500;
    localparam int W1    = 40;
    localparam int N2    = 10;
    localparam int W2    = 25;
    localparam int BASE2 = 20000;
    localparam int ISS1  = N1 * W1;
    localparam int D     = 41 + W1 * (N1 - 1) + ML + 1;
    localparam int DONE2 = D + W2 + W2 * (N2 - 1) + ML + 1;

    logic        clk = 1'b0;
    logic        srstn, conv_done, mem_sel;
    logic [14:0] sram_raddr_weight;
    logic [9:0]  act_raddr, sram_waddr_e, sram_waddr_f;
    logic [1:0]  act_src;
    logic        mac_valid, mac_first, mac_last, layer;
    logic [4:0]  sram_write_enable_e;
    logic [3:0]  sram_bytemask_e, sram_bytemask_f;
    logic        sram_write_enable_f, fc1_done, fc2_done, busy;

    int checks = 0, errors = 0;
    int cycle_cnt = 0, t0 = 0, mode = 0, rst_at = 0, run_id = 0;
    bit chk_on = 1'b0;
    bit ms_lat = 1'b1;

    always #5 clk = ~clk;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    fc_seq_ctrl dut (
        .clk(clk), .srstn(srstn), .conv_done(conv_done), .mem_sel(mem_sel),
        .sram_raddr_weight(sram_raddr_weight), .act_raddr(act_raddr), .act_src(act_src),
        .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last), .layer(layer),
        .sram_write_enable_e(sram_write_enable_e), .sram_waddr_e(sram_waddr_e),
        .sram_bytemask_e(sram_bytemask_e), .sram_write_enable_f(sram_write_enable_f),
        .sram_waddr_f(sram_waddr_f), .sram_bytemask_f(sram_bytemask_f),
        .fc1_done(fc1_done), .fc2_done(fc2_done), .busy(busy)
    );

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s run %0d cycle %0d got %0h expected %0h", nm, run_id, c, act, exp);
        end
    endtask

    always @(negedge clk) begin : cmp
        int c, p, jj, wl, n;
        bit idle, mv;
        logic [31:0] ew, ea, es, ely, ewe, eae, eme, ewf, eaf, emf, ed1, ed2, eb;
        if (chk_on) begin
            c    = cycle_cnt - t0 + 1;
            idle = (mode == 0) || (rst_at != 0 && c > rst_at);
            ew = 0; ea = 0; es = 0; ely = 0; mv = 0; jj = 0; wl = 1;
            ewe = 32'h1F; eae = 0; eme = 32'hF; ewf = 1; eaf = 0; emf = 32'hF;
            ed1 = 0; ed2 = 0; eb = 0;
            if (!idle) begin
                if (c <= ISS1) begin ew = c - 1; ea = (c - 1) % W1; end
                else if (c < D) begin ew = ISS1 - 1; ea = W1 - 1; end
                else if (c < D + N2 * W2) begin ew = BASE2 + c - D; ea = (c - D) % W2; end
                else begin ew = BASE2 + N2 * W2 - 1; ea = W2 - 1; end
                p = c - 1;
                if (p >= 1 && p <= ISS1) begin mv = 1; jj = (p - 1) % W1; wl = W1; end
                else if (p >= D && p < D + N2 * W2) begin mv = 1; jj = (p - D) % W2; wl = W2; end
                ely = (c >= D) ? 1 : 0;
                es  = (c >= D) ? 2 : (ms_lat ? 0 : 1);
                if (c >= 41 + ML && (c - 41 - ML) % W1 == 0 && (c - 41 - ML) / W1 < N1) begin
                    n   = (c - 41 - ML) / W1;
                    ewe = 32'h1F & ~(32'd1 << ((n / 4) % 5));
                    eae = n / 20;
                    eme = 32'hF & ~(32'd1 << (3 - n % 4));
                end
                if (c >= D + W2 + ML && (c - D - W2 - ML) % W2 == 0 && (c - D - W2 - ML) / W2 < N2) begin
                    n   = (c - D - W2 - ML) / W2;
                    ewf = 0;
                    eaf = n / 4;
                    emf = 32'hF & ~(32'd1 << (3 - n % 4));
                end
                ed1 = (c == D) ? 1 : 0;
                ed2 = (c == DONE2) ? 1 : 0;
                eb  = (c >= 1 && c <= DONE2) ? 1 : 0;
            end
            chk("weight_addr", c, 32'(sram_raddr_weight), ew);
            chk("act_raddr", c, 32'(act_raddr), ea);
            chk("act_src", c, 32'(act_src), es);
            chk("mac_valid", c, 32'(mac_valid), 32'(mv));
            chk("mac_first", c, 32'(mac_first), 32'(mv && jj == 0));
            chk("mac_last", c, 32'(mac_last), 32'(mv && jj == wl - 1));
            chk("layer", c, 32'(layer), ely);
            chk("we_e", c, 32'(sram_write_enable_e), ewe);
            chk("we_f", c, 32'(sram_write_enable_f), ewf);
            chk("fc1_done", c, 32'(fc1_done), ed1);
            chk("fc2_done", c, 32'(fc2_done), ed2);
            chk("busy", c, 32'(busy), eb);
            if (ewe != 32'h1F || idle) begin
                chk("waddr_e", c, 32'(sram_waddr_e), eae);
                chk("mask_e", c, 32'(sram_bytemask_e), eme);
            end
            if (ewf == 0 || idle) begin
                chk("waddr_f", c, 32'(sram_waddr_f), eaf);
                chk("mask_f", c, 32'(sram_bytemask_f), emf);
            end
            if (mode == 1 && run_id == 1) begin
                case (c)
                    1:     begin chk("lit_w1", c, 32'(sram_raddr_weight), 0); chk("lit_src1", c, 32'(act_src), 0); end
                    2:     begin chk("lit_mv2", c, 32'(mac_valid), 1); chk("lit_mf2", c, 32'(mac_first), 1); end
                    41:    begin chk("lit_w41", c, 32'(sram_raddr_weight), 40); chk("lit_ml41", c, 32'(mac_last), 1); end
                    43:    begin chk("lit_we43", c, 32'(sram_write_enable_e), 5'b11110); chk("lit_mk43", c, 32'(sram_bytemask_e), 4'b0111); end
                    203:   begin chk("lit_we_n4", c, 32'(sram_write_enable_e), 5'b11101); chk("lit_wa_n4", c, 32'(sram_waddr_e), 0); end
                    883:   begin chk("lit_we_n21", c, 32'(sram_write_enable_e), 5'b11110); chk("lit_wa_n21", c, 32'(sram_waddr_e), 1); chk("lit_mk_n21", c, 32'(sram_bytemask_e), 4'b1011); end
                    20003: begin chk("lit_we_n499", c, 32'(sram_write_enable_e), 5'b01111); chk("lit_wa_n499", c, 32'(sram_waddr_e), 24); chk("lit_mk_n499", c, 32'(sram_bytemask_e), 4'b1110); end
                    20004: begin chk("lit_fc1_done", c, 32'(fc1_done), 1); chk("lit_w20004", c, 32'(sram_raddr_weight), 20000); end
                    20253: chk("lit_w20253", c, 32'(sram_raddr_weight), 20249);
                    20256: begin chk("lit_wf9", c, 32'(sram_write_enable_f), 0); chk("lit_waf9", c, 32'(sram_waddr_f), 2); chk("lit_mkf9", c, 32'(sram_bytemask_f), 4'b1011); end
                    20257: chk("lit_fc2_done", c, 32'(fc2_done), 1);
                    20258: chk("lit_busy_fall", c, 32'(busy), 0);
                    default: ;
                endcase
            end
            if (mode == 1 && run_id == 3 && c == 1)
                chk("lit_restart_w", c, 32'(sram_raddr_weight), 0);
        end
    end

    task automatic start(input bit ms, input int ra, input int rid);
        mem_sel   = ms;
        conv_done = 1'b1;
        @(posedge clk); #1;
        conv_done = 1'b0;
        t0     = cycle_cnt;
        ms_lat = ms;
        rst_at = ra;
        run_id = rid;
        mode   = 1;
        chk_on = 1'b1;
    endtask

    task automatic wait_c(input int n);
        while (cycle_cnt - t0 + 1 < n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_conv();
        conv_done = 1'b1;
        @(posedge clk); #1;
        conv_done = 1'b0;
    endtask

    initial begin
        srstn = 1'b0; conv_done = 1'b1; mem_sel = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        srstn = 1'b1; conv_done = 1'b0;
        mode = 0; chk_on = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        start(1'b1, 0, 1);
        wait_c(100);   pulse_conv();
        wait_c(20100); pulse_conv();
        wait_c(DONE2 + 4);
        chk_on = 1'b0;

        start(1'b0, 5000, 2);
        wait_c(1500); mem_sel = 1'b1;
        wait_c(3000); mem_sel = 1'b0;
        wait_c(4000); mem_sel = 1'b1;
        wait_c(5000);
        srstn = 1'b0;
        @(posedge clk); #1;
        srstn = 1'b1;
        wait_c(5030);
        chk_on = 1'b0;

        start(1'b1, 0, 3);
        wait_c(DONE2 + 4);
        chk_on = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout run %0d", run_id);
        $fatal(1);
    end
endmodule
